// File: rtl/bitstream_aligner.sv
// bitstream_aligner
//   Collects WORD_W-bit words into a 2*WORD_W-bit left-justified bit buffer
//   and presents the oldest WIN_W bits as a window. The consumer removes
//   0..WIN_W bits from the window head each cycle; in the same cycle a new
//   word may be appended behind whatever bits remain.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset (clears buffer, count, err)
//   flush     : synchronous clear of buffered bits (err is kept)
//   in_valid  : in_data holds a word
//   in_data   : input word, MSB is the first bit of the stream
//   in_ready  : a word is accepted this cycle (room for a full word, no flush)
//   cons_n    : number of bits to consume from the window head
//   cons_en   : qualifies cons_n
//   win       : oldest WIN_W buffered bits, win[WIN_W-1] is the oldest
//   avail     : number of valid buffered bits, 0..2*WORD_W
//   err       : sticky flag, set by a consume larger than avail or WIN_W
module bitstream_aligner #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 32,
    localparam int BUF_W = 2 * WORD_W,
    localparam int CNT_W = $clog2(BUF_W + 1),
    localparam int N_W   = $clog2(WIN_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic [N_W-1:0]    cons_n,
    input  logic              cons_en,
    output logic [WIN_W-1:0]  win,
    output logic [CNT_W-1:0]  avail,
    output logic              err
);

    logic [BUF_W-1:0] bits_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             err_p1;

    logic             fire;
    logic             legal;
    logic             illegal;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] shift;
    logic [BUF_W-1:0] data_ext;
    logic [BUF_W-1:0] bits_next;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic consume_legal(input logic en,
                                           input logic [N_W-1:0] n,
                                           input logic [CNT_W-1:0] cnt);
        return en && (CNT_W'(n) <= cnt) && (n <= N_W'(WIN_W));
    endfunction

    // Ready only looks at the registered count, never at the consume inputs,
    // so a word is accepted only when a full word fits before any consume.
    assign in_ready = (cnt_p1 <= CNT_W'(WORD_W)) && !flush;
    assign fire     = in_valid && in_ready;

    always_comb begin
        legal     = consume_legal(cons_en, cons_n, cnt_p1);
        illegal   = cons_en && !legal;
        n_eff     = legal ? CNT_W'(cons_n) : '0;
        rem       = cnt_p1 - n_eff;
        // The new word lands directly behind the remaining bits; with
        // cnt <= WORD_W whenever fire is set, this shift is never negative.
        shift     = CNT_W'(WORD_W) - rem;
        data_ext  = {{WORD_W{1'b0}}, in_data};
        bits_next = bits_p1 << n_eff;
        cnt_next  = rem;
        if (fire) begin
            bits_next = bits_next | (data_ext << shift);
            cnt_next  = rem + CNT_W'(WORD_W);
        end
    end

    // ---- stage p1: buffer, count and error registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_p1 <= '0;
            cnt_p1  <= '0;
            err_p1  <= 1'b0;
        end else if (flush) begin
            bits_p1 <= '0;
            cnt_p1  <= '0;
        end else begin
            bits_p1 <= bits_next;
            cnt_p1  <= cnt_next;
            if (illegal)
                err_p1 <= 1'b1;
        end
    end

    assign win   = bits_p1[BUF_W-1 -: WIN_W];
    assign avail = cnt_p1;
    assign err   = err_p1;

endmodule
